// File: rtl/axis_gate_controller_pkg.sv
// ---------------------------------------------------------------------------
// axis_gate_controller_pkg
//   Shared definitions for the acquisition-window gate controller: the
//   state encoding, which the status register map also decodes, and its width.
// ---------------------------------------------------------------------------
package axis_gate_controller_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_DELAY = 3'd2,
    ST_OPEN  = 3'd3,
    ST_DONE  = 3'd4
  } gate_state_t;

endpackage

// File: rtl/axis_gate_controller_if.sv
// ---------------------------------------------------------------------------
// axis_gate_controller_if
//   Minimal AXI4-Stream bundle (tdata/tvalid/tready).
//   master : drives tdata/tvalid, receives tready
//   slave  : receives tdata/tvalid, drives tready
// ---------------------------------------------------------------------------
interface axis_gate_controller_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input  tready);
  modport slave  (input  tdata, input  tvalid, output tready);

endinterface

// File: rtl/axis_gate_controller_edge_detector_rise.sv
// ---------------------------------------------------------------------------
// edge_detector_rise
//   Rising-edge detector for a level already synchronous to clk. The previous
//   level is registered; the pulse is combinational, so it is high in the same
//   cycle the input first reads high.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : level input
//   pulse      : din & ~din_prev
// ---------------------------------------------------------------------------
module edge_detector_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic din_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!rst_n) din_prev <= 1'b0;
    else        din_prev <= din;
  end

  assign pulse = din & ~din_prev;

endmodule

// File: rtl/axis_gate_controller.sv
// ---------------------------------------------------------------------------
// axis_gate_controller
//   Acquisition-window sequencer on an AXI4-Stream sample path. After arm, it
//   waits for a trigger rising edge, discards cfg_delay beats, passes exactly
//   cfg_length beats and stops. Outside the window input beats are accepted
//   and dropped so the source is never stalled.
//
//   aclk, aresetn          clock, asynchronous active-low reset
//   cfg_delay, cfg_length  window configuration, captured on arm
//   arm, abort             1-cycle control pulses (abort wins)
//   trg_in                 trigger level, synchronous to aclk
//   gate_flag              high exactly while the window is OPEN
//   sts_state, sts_count   current state, beats passed in current/last window
//   s_axis                 sample input stream (slave)
//   m_axis                 gated output stream (master), data passes straight through
// ---------------------------------------------------------------------------
module axis_gate_controller
  import axis_gate_controller_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [CNTR_WIDTH-1:0]  cfg_delay,
  input  logic [CNTR_WIDTH-1:0]  cfg_length,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   trg_in,
  output logic                   gate_flag,
  output logic [STATE_WIDTH-1:0] sts_state,
  output logic [CNTR_WIDTH-1:0]  sts_count,
  axis_gate_controller_if.slave  s_axis,
  axis_gate_controller_if.master m_axis
);

  gate_state_t           state_q, state_d;
  logic [CNTR_WIDTH-1:0] delay_q, length_q, dly_cnt_q, sts_count_q;
  logic                  trg_edge;
  logic                  drop_beat;
  logic                  xfer;

  edge_detector_rise u_trg_edge (
    .clk   (aclk),
    .rst_n (aresetn),
    .din   (trg_in),
    .pulse (trg_edge)
  );

  assign drop_beat = (state_q == ST_DELAY) && s_axis.tvalid;
  assign xfer      = (state_q == ST_OPEN) && s_axis.tvalid && m_axis.tready;

  // Next-state decode. Delay/length are non-zero whenever DELAY/OPEN is
  // reached, so the "- 1" compares never wrap.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      ST_ARMED: begin
        if (trg_edge) begin
          if (length_q == '0)     state_d = ST_DONE;
          else if (delay_q == '0) state_d = ST_OPEN;
          else                    state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (drop_beat && (dly_cnt_q == delay_q - CNTR_WIDTH'(1))) state_d = ST_OPEN;
      end
      ST_OPEN: begin
        if (xfer && (sts_count_q == length_q - CNTR_WIDTH'(1))) state_d = ST_DONE;
      end
      default: state_d = state_q;   // IDLE and DONE wait for arm/abort
    endcase
    // Arm overrides any trigger edge in the same cycle; abort overrides arm.
    if (arm)   state_d = ST_ARMED;
    if (abort) state_d = ST_IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    // NOTE: only control/config registers live here, no storage arrays, so
    // resetting all of them is cheap and gives a defined power-up window.
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      gate_flag   <= 1'b0;
      delay_q     <= '0;
      length_q    <= '0;
      dly_cnt_q   <= '0;
      sts_count_q <= '0;
    end else begin
      state_q   <= state_d;
      // Registered from next state, so it rises and falls with OPEN itself.
      gate_flag <= (state_d == ST_OPEN);
      if (abort) begin
        // Counters frozen: sts_count reports how far the aborted window got.
      end else if (arm) begin
        delay_q     <= cfg_delay;
        length_q    <= cfg_length;
        dly_cnt_q   <= '0;
        sts_count_q <= '0;
      end else begin
        if (drop_beat) dly_cnt_q   <= dly_cnt_q + CNTR_WIDTH'(1);
        if (xfer)      sts_count_q <= sts_count_q + CNTR_WIDTH'(1);
      end
    end
  end

  // Stream gating: pass-through with back-pressure only while OPEN,
  // otherwise swallow beats so the source never stalls.
  always_comb begin
    s_axis.tready = 1'b1;
    m_axis.tvalid = 1'b0;
    if (state_q == ST_OPEN) begin
      s_axis.tready = m_axis.tready;
      m_axis.tvalid = s_axis.tvalid;
    end
  end

  assign m_axis.tdata = AXIS_TDATA_WIDTH'(s_axis.tdata);
  assign sts_state    = state_q;
  assign sts_count    = sts_count_q;

endmodule

// File: tb/tb_axis_gate_controller.sv
module tb_axis_gate_controller;
  import axis_gate_controller_pkg::*;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [31:0] cfg_delay, cfg_length;
  logic        arm, abort, trg_in;
  logic        gate_flag;
  logic [2:0]  sts_state;
  logic [31:0] sts_count;

  axis_gate_controller_if #(.DATA_WIDTH(32)) s_axis ();
  axis_gate_controller_if #(.DATA_WIDTH(32)) m_axis ();

  axis_gate_controller #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_delay  (cfg_delay),
    .cfg_length (cfg_length),
    .arm        (arm),
    .abort      (abort),
    .trg_in     (trg_in),
    .gate_flag  (gate_flag),
    .sts_state  (sts_state),
    .sts_count  (sts_count),
    .s_axis     (s_axis),
    .m_axis     (m_axis)
  );

  always #5 aclk = ~aclk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] out_q[$];
  logic [31:0] t0;
  logic        src_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1. Handshakes are sampled on the negedge (inputs stable,
  // state stable); the source advances its data only on an accepted beat.
  task automatic tick();
    @(negedge aclk);
    if (m_axis.tvalid && m_axis.tready) out_q.push_back(m_axis.tdata);
    src_hs = s_axis.tvalid && s_axis.tready;
    @(posedge aclk);
    #1;
    if (src_hs) s_axis.tdata = s_axis.tdata + 32'd1;
    cyc++;
  endtask

  task automatic do_arm(input logic [31:0] d, input logic [31:0] l);
    cfg_delay = d; cfg_length = l; arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; arm = 1'b0; abort = 1'b0; trg_in = 1'b0;
    cfg_delay = '0; cfg_length = '0;
    s_axis.tdata = 32'd100; s_axis.tvalid = 1'b1; m_axis.tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_state",  sts_state,     ST_IDLE);
    check("rst_gate",   gate_flag,     1'b0);
    check("rst_count",  sts_count,     32'd0);
    check("rst_mvalid", m_axis.tvalid, 1'b0);
    check("rst_sready", s_axis.tready, 1'b1);
    aresetn = 1'b1;
    tick();

    // delay=3, length=5, continuous valid, trigger at cycle 10
    do_arm(32'd3, 32'd5);
    check("t2_armed", sts_state, ST_ARMED);
    while (cyc < 10) tick();
    out_q.delete();
    trg_in = 1'b1;
    t0 = s_axis.tdata;
    tick();
    check("t2_delay", sts_state, ST_DELAY);
    for (int i = 0; i < 3; i++) begin
      check("t2_sready_dly", s_axis.tready, 1'b1);
      tick();
    end
    check("t2_open", sts_state, ST_OPEN);
    check("t2_gate", gate_flag, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("t2_sready_open", s_axis.tready, 1'b1);
      tick();
    end
    check("t2_done",   sts_state, ST_DONE);
    check("t2_gate0",  gate_flag, 1'b0);
    check("t2_count",  sts_count, 32'd5);
    check("t2_nbeats", out_q.size(), 5);
    check("t2_first",  out_q[0], t0 + 32'd4);
    check("t2_last",   out_q[4], t0 + 32'd8);
    check("t2_sready_done", s_axis.tready, 1'b1);

    // delay=0, length=4, m_axis_tready toggling 1010
    trg_in = 1'b0;
    do_arm(32'd0, 32'd4);
    out_q.delete();
    trg_in = 1'b1;
    t0 = s_axis.tdata;
    tick();
    check("t3_open", sts_state, ST_OPEN);
    for (int i = 0; i < 8; i++) begin
      m_axis.tready = (i % 2 == 0);
      #1;
      check("t3_sready", s_axis.tready, (i == 7) ? 1'b1 : m_axis.tready);
      tick();
    end
    m_axis.tready = 1'b1;
    check("t3_done",   sts_state, ST_DONE);
    check("t3_count",  sts_count, 32'd4);
    check("t3_nbeats", out_q.size(), 4);
    check("t3_b0", out_q[0], t0 + 32'd1);
    check("t3_b1", out_q[1], t0 + 32'd2);
    check("t3_b2", out_q[2], t0 + 32'd3);
    check("t3_b3", out_q[3], t0 + 32'd4);

    // length=0: ARMED -> DONE, no output beats; DONE ignores later edges
    trg_in = 1'b0;
    do_arm(32'd5, 32'd0);
    out_q.delete();
    check("t4_armed", sts_state, ST_ARMED);
    trg_in = 1'b1;
    tick();
    check("t4_done", sts_state, ST_DONE);
    check("t4_mvalid", m_axis.tvalid, 1'b0);
    trg_in = 1'b0;
    tick();
    trg_in = 1'b1;
    tick();
    check("t4_hold",   sts_state, ST_DONE);
    check("t4_nbeats", out_q.size(), 0);

    // arm and trigger edge in the same cycle; held-high trigger
    trg_in = 1'b0;
    tick();
    trg_in = 1'b1;
    do_arm(32'd0, 32'd2);
    check("t5_armed", sts_state, ST_ARMED);
    repeat (3) tick();
    check("t5_held", sts_state, ST_ARMED);
    trg_in = 1'b0;
    tick();
    trg_in = 1'b1;
    tick();
    check("t5_open", sts_state, ST_OPEN);
    repeat (2) tick();
    check("t5_done",  sts_state, ST_DONE);
    check("t5_count", sts_count, 32'd2);

    // abort during DELAY, then a fresh delay=2 length=2 window
    trg_in = 1'b0;
    do_arm(32'd10, 32'd3);
    trg_in = 1'b1;
    tick();
    repeat (3) tick();
    check("t6_delay", sts_state, ST_DELAY);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_idle", sts_state, ST_IDLE);
    trg_in = 1'b0;
    do_arm(32'd2, 32'd2);
    out_q.delete();
    trg_in = 1'b1;
    t0 = s_axis.tdata;
    tick();
    tick();
    check("t6_still_delay", sts_state, ST_DELAY);
    tick();
    check("t6_open", sts_state, ST_OPEN);
    repeat (2) tick();
    check("t6_done",  sts_state, ST_DONE);
    check("t6_count", sts_count, 32'd2);
    check("t6_b0", out_q[0], t0 + 32'd3);
    check("t6_b1", out_q[1], t0 + 32'd4);

    // abort during OPEN keeps sts_count
    trg_in = 1'b0;
    do_arm(32'd0, 32'd10);
    trg_in = 1'b1;
    tick();
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t7_idle",  sts_state, ST_IDLE);
    check("t7_count", sts_count, 32'd3);
    check("t7_gate",  gate_flag, 1'b0);

    // reset mid-OPEN
    trg_in = 1'b0;
    do_arm(32'd0, 32'd100);
    trg_in = 1'b1;
    tick();
    repeat (2) tick();
    check("t1_gate_open", gate_flag, 1'b1);
    aresetn = 1'b0;
    tick();
    check("t1_state",  sts_state,     ST_IDLE);
    check("t1_gate",   gate_flag,     1'b0);
    check("t1_count",  sts_count,     32'd0);
    check("t1_mvalid", m_axis.tvalid, 1'b0);
    aresetn = 1'b1;
    tick();
    check("t1_idle_after", sts_state, ST_IDLE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
